// File: rtl/alu_pkg.sv
// Shared encodings and request record for the shared 16-bit ALU and its arbiter.
package alu_pkg;

   localparam int DW = 16;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_NAND = 2'b01,
      ALU_NOP  = 2'b10
   } alu_op_e;

   typedef enum logic [1:0] {
      COND_ALWAYS = 2'b00,
      COND_C      = 2'b01,
      COND_Z      = 2'b10,
      COND_NEVER  = 2'b11
   } cond_e;

   typedef struct packed {
      logic [1:0]    op;
      logic [1:0]    cond;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic          cwe;
      logic          zwe;
   } alu_req_t;

   // Reserved op 2'b11 never reaches the ALU; it runs as a no-op.
   function automatic logic [1:0] drive_op(input logic [1:0] op);
      return (op == 2'b11) ? ALU_NOP : op;
   endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// Architectural C/Z flags: condition evaluation and gated flag writes.
module alu_flag_reg
   import alu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       fire,
   input  logic [1:0] op,
   input  logic [1:0] cond,
   input  logic       cwe,
   input  logic       zwe,
   input  logic       alu_carry,
   input  logic       alu_zero,
   output logic       flag_c,
   output logic       flag_z,
   output logic       cond_ok
);

   always_comb begin
      cond_ok = 1'b0;
      case (cond)
         COND_ALWAYS: cond_ok = 1'b1;
         COND_C:      cond_ok = flag_c;
         COND_Z:      cond_ok = flag_z;
         default:     cond_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flag_c <= 1'b0;
         flag_z <= 1'b0;
      end else if (fire && cond_ok) begin
         if (cwe && op == ALU_ADD)
            flag_c <= alu_carry;
         if (zwe && (op == ALU_ADD || op == ALU_NAND))
            flag_z <= alu_zero;
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-port arbiter for the shared ALU with registered result and port-1 starvation guard.
// Optional performance counters are built when ALU_ARB_STATS_EN is defined.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int DW       = alu_pkg::DW,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [1:0]    req0_op,
   input  logic [1:0]    req0_cond,
   input  logic [DW-1:0] req0_a,
   input  logic [DW-1:0] req0_b,
   input  logic          req0_cwe,
   input  logic          req0_zwe,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [1:0]    req1_op,
   input  logic [1:0]    req1_cond,
   input  logic [DW-1:0] req1_a,
   input  logic [DW-1:0] req1_b,
   input  logic          req1_cwe,
   input  logic          req1_zwe,
   output logic          rsp0_valid,
   output logic          rsp1_valid,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_skipped,
   output logic [DW-1:0] alu_in1,
   output logic [DW-1:0] alu_in2,
   output logic [1:0]    alu_op,
   input  logic [DW-1:0] alu_out,
   input  logic          alu_zero,
   input  logic          alu_carry,
   output logic          flag_c,
   output logic          flag_z,
   output logic [15:0]   stat_grant0,
   output logic [15:0]   stat_grant1,
   output logic [15:0]   stat_stall1
);

   localparam int SW = $clog2(MAX_WAIT + 1);

   alu_req_t       r0, r1, sel;
   logic           grant0, grant1, gnt, cond_ok, starved;
   logic [SW-1:0]  starve_cnt;

   assign r0 = '{op: req0_op, cond: req0_cond, a: req0_a, b: req0_b, cwe: req0_cwe, zwe: req0_zwe};
   assign r1 = '{op: req1_op, cond: req1_cond, a: req1_a, b: req1_b, cwe: req1_cwe, zwe: req1_zwe};

   // No grants while reset is high, so nothing is launched into a flushed pipe.
   assign starved    = (starve_cnt == SW'(MAX_WAIT));
   assign grant1     = !reset && req1_valid && (!req0_valid || starved);
   assign grant0     = !reset && req0_valid && !grant1;
   assign gnt        = grant0 || grant1;
   assign sel        = grant1 ? r1 : r0;
   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_comb begin
      alu_op  = ALU_NOP;
      alu_in1 = '0;
      alu_in2 = '0;
      if (gnt) begin
         alu_op  = drive_op(sel.op);
         alu_in1 = sel.a;
         alu_in2 = sel.b;
      end
   end

   alu_flag_reg u_flags (
      .clk       (clk),
      .reset     (reset),
      .fire      (gnt),
      .op        (sel.op),
      .cond      (sel.cond),
      .cwe       (sel.cwe),
      .zwe       (sel.zwe),
      .alu_carry (alu_carry),
      .alu_zero  (alu_zero),
      .flag_c    (flag_c),
      .flag_z    (flag_z),
      .cond_ok   (cond_ok)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp0_valid  <= 1'b0;
         rsp1_valid  <= 1'b0;
         rsp_data    <= '0;
         rsp_skipped <= 1'b0;
         starve_cnt  <= '0;
      end else begin
         rsp0_valid <= grant0;
         rsp1_valid <= grant1;
         if (gnt) begin
            rsp_skipped <= !cond_ok;
            rsp_data    <= cond_ok ? alu_out : '0;
         end
         if (!req1_valid || grant1)
            starve_cnt <= '0;
         else if (!starved)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

`ifdef ALU_ARB_STATS_EN
   logic [15:0] cnt_g0, cnt_g1, cnt_s1;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_g0 <= '0;
         cnt_g1 <= '0;
         cnt_s1 <= '0;
      end else begin
         if (grant0 && cnt_g0 != 16'hFFFF)
            cnt_g0 <= cnt_g0 + 1'b1;
         if (grant1 && cnt_g1 != 16'hFFFF)
            cnt_g1 <= cnt_g1 + 1'b1;
         if (req1_valid && !grant1 && cnt_s1 != 16'hFFFF)
            cnt_s1 <= cnt_s1 + 1'b1;
      end
   end

   assign stat_grant0 = cnt_g0;
   assign stat_grant1 = cnt_g1;
   assign stat_stall1 = cnt_s1;
`else
   assign stat_grant0 = '0;
   assign stat_grant1 = '0;
   assign stat_stall1 = '0;
`endif

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational 16-bit ALU (add/nand/disabled) between two requesters: port 0 = EX stage (normal priority winner), port 1 = LM/SM address sequencer.
- Owns the architectural carry (C) and zero (Z) flag registers.
- Evaluates conditional-execute codes (ADC/ADZ-style) against the flags.
- Registers the result, with a starvation guard for port 1.

Parameters:
- DW, 16, datapath width (ALU fixed at 16)
- MAX_WAIT, 4, consecutive lost cycles of port 1 before it is forced to win (1..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req0_valid  in  1  port 0 request
- req0_ready  out  1  port 0 granted this cycle (combinational)
- req0_op  in  2  00 add, 01 nand, 10 none, 11 reserved
- req0_cond  in  2  00 always, 01 only if C=1, 10 only if Z=1, 11 never
- req0_a, req0_b  in  DW  operands
- req0_cwe, req0_zwe  in  1  carry/zero flag write enables
- req1_*  same set as port 0, for port 1
- rsp0_valid, rsp1_valid  out  1  result valid, one cycle after grant
- rsp_data  out  DW  registered ALU result
- rsp_skipped  out  1  condition failed; data forced 0; flags untouched
- alu_in1, alu_in2  out  DW  to ALU
- alu_op  out  2  to ALU; 10 when idle
- alu_out  in  DW  from ALU
- alu_zero, alu_carry  in  1  from ALU
- flag_c, flag_z  out  1  current flag registers
- stat_grant0, stat_grant1, stat_stall1  out  16  performance counters (see Optional Feature)

Behaviour:
- Reset (synchronous): flag_c=0, flag_z=0, rsp0/1_valid=0, rsp_data=0, rsp_skipped=0, starve counter=0, stat counters=0.
- ALU drive while reset is high: alu_op=10, alu_in1=alu_in2=0.
- Arbitration, combinational, at most one grant per cycle:
  - Only one valid: it wins.
  - Both valid: port 0 wins, unless starve_cnt==MAX_WAIT, in which case port 1 wins.
  - readyN=validN & won.
  - A requester holds valid and all fields stable until ready.
- ALU drive: the granted request's a/b/op appear on alu_in1/in2/alu_op.
  - No grant: alu_op=10, operands 0.
  - Op 11 is driven as 10.
- Condition check uses the flag registers as they stand at the start of the grant cycle.
  - Fail: rsp_skipped=1, rsp_data=0, no flag write.
- Result latency is exactly 1 cycle. On the edge after a grant:
  - rspN_valid=1 for the winner, for one cycle.
  - rsp_data=alu_out (or 0 if skipped).
- Flag update on the same edge, only if the condition passed:
  - C<=alu_carry if cwe and op==00.
  - Z<=alu_zero if zwe and op in {00,01}.
  - Op 10/11 never writes flags.
- Back-to-back grants are legal. The second op's condition sees flags written by the first (one-edge visibility, no bypass needed).
- Starve counter (width clog2(MAX_WAIT+1)):
  - Increments when req1_valid & !req1_ready; saturates at MAX_WAIT.
  - Clears to 0 on req1 grant or when req1_valid=0.
- Reset mid-operation: a pending grant's result and flag writes are discarded. rsp valids are 0 the cycle after reset deasserts.

Optional Feature:
- ALU_ARB_STATS_EN defined:
  - stat_grant0/1 count grants per port.
  - stat_stall1 counts cycles with req1_valid & !req1_ready.
  - All three are 16-bit, saturate at 16'hFFFF, and are cleared by reset.
- Undefined: all stat_* outputs tied to 0, no counter flops inferred.

Decomposition:
- Shared package alu_pkg:
  - op encodings ALU_ADD=2'b00, ALU_NAND=2'b01, ALU_NOP=2'b10.
  - cond encodings COND_ALWAYS/COND_C/COND_Z/COND_NEVER.
  - DW constant.
- One natural sub-module: alu_flag_reg. It holds C/Z, evaluates the condition, and applies the gated write enables. The arbiter top instantiates it.

Test Plan:
- Single port 0 add 0xFFFF+0x0001, cwe=zwe=1 -> next cycle rsp0_valid=1, rsp_data=0x0000, flag_c=1, flag_z=1.
- Both valid every cycle, MAX_WAIT=4 -> grants 0,0,0,0,1,0,0,0,0,1…; stat_stall1 increments 4 per period when the feature is enabled.
- Carry fix-up: port 0 add with cond=01 (only if C=1) after an add that left C=0 -> rsp_skipped=1, rsp_data=0, flags unchanged. Repeat after 0x8000+0x8000 (C=1) -> executes.
- Nand 0xFFFF,0xFFFF with zwe=1, cwe=1 -> rsp_data=0x0000, Z=1, C unchanged.
- Idle with no valid -> alu_op=10, ready=0, no rsp valid, flags stable. Op=11 request -> granted, rsp_data=0, no flag change.
- Reset asserted in the cycle after a grant -> rsp valids 0, flags 0, starve counter 0. Without ALU_ARB_STATS_EN, all stat_* read 0 throughout.
